// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: one AHB-Lite master-side bundle (address phase, write data,
// and the slave returns). The arbiter sees each master through the slave
// modport and drives the shared bus through the master modport.
interface ahb_arbiter_if;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output htrans, haddr, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  htrans, haddr, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master AHB-Lite arbiter (SPI loader vs. RISC-V core).
// The address phase comes from the registered address owner, the write data
// from the owner of the in-flight data phase. Ownership moves only when the
// owner is idle, unlocked and the bus is ready; core_rst pins it to SPI.
module ahb_arbiter (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_rst,
  ahb_arbiter_if.slave  spi,
  ahb_arbiter_if.slave  core,
  ahb_arbiter_if.master bus,
  output logic          core_grant
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_CORE = 1'b1
  } owner_e;

  owner_e      addr_owner_r;
  owner_e      addr_owner_next_s;
  owner_e      dp_owner_r;
  logic        dp_valid_r;
  logic [1:0]  owner_htrans_s;
  logic        owner_lock_s;
  logic [1:0]  other_htrans_s;
  logic        boundary_s;

  // A master that does not own the address phase is released only to finish
  // its own last data phase; otherwise it is ready only while idle.
  function automatic logic nonowner_ready(input logic [1:0] htrans,
                                          input logic       owns_dp,
                                          input logic       hready);
    logic rdy;
    if (owns_dp) begin
      rdy = hready;
    end else begin
      rdy = (htrans == HTRANS_IDLE);
    end
    return rdy;
  endfunction

  // Ownership register and data-phase tracking; everything holds on wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_owner_r <= OWN_SPI;
      dp_owner_r   <= OWN_SPI;
      dp_valid_r   <= 1'b0;
    end else begin
      addr_owner_r <= addr_owner_next_s;
      if (bus.hready) begin
        dp_owner_r <= addr_owner_r;
        dp_valid_r <= bus.htrans[1];
      end else begin
        dp_owner_r <= dp_owner_r;
        dp_valid_r <= dp_valid_r;
      end
    end
  end

  // Next-owner decision: only at an idle, unlocked, ready boundary.
  always_comb begin
    owner_htrans_s    = spi.htrans;
    owner_lock_s      = spi.hmastlock;
    other_htrans_s    = core.htrans;
    addr_owner_next_s = addr_owner_r;
    if (addr_owner_r == OWN_CORE) begin
      owner_htrans_s = core.htrans;
      owner_lock_s   = core.hmastlock;
      other_htrans_s = spi.htrans;
    end else begin
      owner_htrans_s = spi.htrans;
      owner_lock_s   = spi.hmastlock;
      other_htrans_s = core.htrans;
    end
    boundary_s = bus.hready && (owner_htrans_s == HTRANS_IDLE) && !owner_lock_s;
    if (boundary_s) begin
      if (core_rst) begin
        addr_owner_next_s = OWN_SPI;
      end else if (other_htrans_s == HTRANS_NONSEQ) begin
        addr_owner_next_s = (addr_owner_r == OWN_CORE) ? OWN_SPI : OWN_CORE;
      end else begin
        addr_owner_next_s = addr_owner_r;
      end
    end else begin
      addr_owner_next_s = addr_owner_r;
    end
  end

  // Shared-bus address/control from the address owner, write data from the data-phase owner.
  always_comb begin
    bus.htrans    = spi.htrans;
    bus.haddr     = spi.haddr;
    bus.hwrite    = spi.hwrite;
    bus.hsize     = spi.hsize;
    bus.hburst    = spi.hburst;
    bus.hprot     = spi.hprot;
    bus.hmastlock = spi.hmastlock;
    bus.hwdata    = spi.hwdata;
    if (addr_owner_r == OWN_CORE) begin
      bus.htrans    = core.htrans;
      bus.haddr     = core.haddr;
      bus.hwrite    = core.hwrite;
      bus.hsize     = core.hsize;
      bus.hburst    = core.hburst;
      bus.hprot     = core.hprot;
      bus.hmastlock = core.hmastlock;
    end else begin
      bus.htrans    = spi.htrans;
      bus.haddr     = spi.haddr;
      bus.hwrite    = spi.hwrite;
      bus.hsize     = spi.hsize;
      bus.hburst    = spi.hburst;
      bus.hprot     = spi.hprot;
      bus.hmastlock = spi.hmastlock;
    end
    if (dp_owner_r == OWN_CORE) begin
      bus.hwdata = core.hwdata;
    end else begin
      bus.hwdata = spi.hwdata;
    end
  end

  // Ready and response routing back to each master.
  always_comb begin
    spi.hready  = 1'b0;
    core.hready = 1'b0;
    spi.hresp   = 1'b0;
    core.hresp  = 1'b0;
    if (addr_owner_r == OWN_CORE) begin
      core.hready = bus.hready;
      spi.hready  = nonowner_ready(spi.htrans, dp_valid_r && (dp_owner_r == OWN_SPI), bus.hready);
    end else begin
      spi.hready  = bus.hready;
      core.hready = nonowner_ready(core.htrans, dp_valid_r && (dp_owner_r == OWN_CORE), bus.hready);
    end
    if (dp_valid_r) begin
      if (dp_owner_r == OWN_CORE) begin
        core.hresp = bus.hresp;
      end else begin
        spi.hresp = bus.hresp;
      end
    end else begin
      spi.hresp  = 1'b0;
      core.hresp = 1'b0;
    end
  end

  assign spi.hrdata  = bus.hrdata;
  assign core.hrdata = bus.hrdata;
  assign core_grant  = (addr_owner_r == OWN_CORE);

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios followed by random traffic, each cycle
// compared against a reference model of the arbitration rules.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic core_rst;
  logic core_grant;

  ahb_arbiter_if spi_if();
  ahb_arbiter_if core_if();
  ahb_arbiter_if bus_if();

  ahb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .core_rst   (core_rst),
    .spi        (spi_if),
    .core       (core_if),
    .bus        (bus_if),
    .core_grant (core_grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model: master index 0 = SPI, 1 = core
  int m_own    = 0;
  int m_dp_own = 0;
  bit m_dp_real = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [1:0] trans_of(input int m);
    return (m == 1) ? core_if.htrans : spi_if.htrans;
  endfunction

  function automatic logic lock_of(input int m);
    return (m == 1) ? core_if.hmastlock : spi_if.hmastlock;
  endfunction

  function automatic logic exp_ready(input int m);
    if (m == m_own) return bus_if.hready;
    if (m_dp_real && m_dp_own == m) return bus_if.hready;
    return trans_of(m) == IDLE;
  endfunction

  function automatic logic exp_resp(input int m);
    return (m_dp_real && m_dp_own == m) ? bus_if.hresp : 1'b0;
  endfunction

  task automatic model_reset();
    m_own = 0;
    m_dp_own = 0;
    m_dp_real = 1'b0;
  endtask

  task automatic check_cycle();
    logic [11:0] ctl_spi, ctl_core, ctl_bus;
    ctl_spi  = {spi_if.hwrite, spi_if.hsize, spi_if.hburst, spi_if.hprot, spi_if.hmastlock};
    ctl_core = {core_if.hwrite, core_if.hsize, core_if.hburst, core_if.hprot, core_if.hmastlock};
    ctl_bus  = {bus_if.hwrite, bus_if.hsize, bus_if.hburst, bus_if.hprot, bus_if.hmastlock};
    chk("haddr", bus_if.haddr, (m_own == 1) ? core_if.haddr : spi_if.haddr);
    chk("htrans", 32'(bus_if.htrans), 32'(trans_of(m_own)));
    chk("hctl", 32'(ctl_bus), 32'((m_own == 1) ? ctl_core : ctl_spi));
    chk("hwdata", bus_if.hwdata, (m_dp_own == 1) ? core_if.hwdata : spi_if.hwdata);
    chk("spi_hready", 32'(spi_if.hready), 32'(exp_ready(0)));
    chk("core_hready", 32'(core_if.hready), 32'(exp_ready(1)));
    chk("spi_hresp", 32'(spi_if.hresp), 32'(exp_resp(0)));
    chk("core_hresp", 32'(core_if.hresp), 32'(exp_resp(1)));
    chk("core_grant", 32'(core_grant), 32'(m_own));
    chk("spi_hrdata", spi_if.hrdata, bus_if.hrdata);
    chk("core_hrdata", core_if.hrdata, bus_if.hrdata);
  endtask

  // check at the falling edge, advance the model, then step past the rising edge
  task automatic tick();
    @(negedge clk);
    check_cycle();
    if (reset) begin
      model_reset();
    end else if (bus_if.hready) begin
      int nxt;
      logic [1:0] ot;
      nxt = m_own;
      ot = trans_of(m_own);
      if (ot == IDLE && !lock_of(m_own)) begin
        if (core_rst) nxt = 0;
        else if (trans_of(1 - m_own) == NONSEQ) nxt = 1 - m_own;
      end
      m_dp_own  = m_own;
      m_dp_real = (ot == NONSEQ) || (ot == SEQ);
      m_own     = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic [1:0] tr, input logic [31:0] ad,
                       input logic wr, input logic [2:0] bu, input logic lk);
    if (m == 1) begin
      core_if.htrans = tr; core_if.haddr = ad; core_if.hwrite = wr;
      core_if.hburst = bu; core_if.hmastlock = lk;
    end else begin
      spi_if.htrans = tr; spi_if.haddr = ad; spi_if.hwrite = wr;
      spi_if.hburst = bu; spi_if.hmastlock = lk;
    end
  endtask

  task automatic rand_master(input int m);
    int r;
    logic [1:0] tr;
    r = $urandom_range(0, 9);
    tr = (r < 4) ? IDLE : (r < 7) ? NONSEQ : (r < 9) ? SEQ : 2'b01;
    drive(m, tr, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 4) == 0));
    if (m == 1) begin
      core_if.hsize = 3'($urandom_range(0, 7)); core_if.hprot = 4'($urandom_range(0, 15));
      core_if.hwdata = $urandom;
    end else begin
      spi_if.hsize = 3'($urandom_range(0, 7)); spi_if.hprot = 4'($urandom_range(0, 15));
      spi_if.hwdata = $urandom;
    end
  endtask

  initial begin
    reset = 1'b1;
    core_rst = 1'b1;
    drive(0, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    drive(1, IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    spi_if.hsize = 3'b010; spi_if.hprot = 4'b0011; spi_if.hwdata = 32'h0;
    core_if.hsize = 3'b010; core_if.hprot = 4'b0011; core_if.hwdata = 32'h0;
    bus_if.hready = 1'b1; bus_if.hresp = 1'b0; bus_if.hrdata = 32'h0;
    model_reset();
    #1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("rst_grant", 32'(core_grant), 32'd0);
    chk("rst_core_hready_idle", 32'(core_if.hready), 32'd1);
    tick();

    // SPI-only write while the core is held in reset
    drive(0, NONSEQ, 32'h100, 1'b1, 3'b000, 1'b0);
    drive(1, NONSEQ, 32'h200, 1'b0, 3'b000, 1'b0);
    #2;
    chk("spi_wr_addr", bus_if.haddr, 32'h100);
    chk("spi_wr_core_stalled", 32'(core_if.hready), 32'd0);
    tick();
    drive(0, IDLE, 32'h100, 1'b0, 3'b000, 1'b0);
    spi_if.hwdata = 32'hDEADBEEF;
    #2;
    chk("spi_wr_data", bus_if.hwdata, 32'hDEADBEEF);
    tick();
    chk("spi_wr_grant", 32'(core_grant), 32'd0);

    // handover to the core
    core_rst = 1'b0;
    #2;
    chk("ho_core_hready", 32'(core_if.hready), 32'd0);
    chk("ho_bus_idle", 32'(bus_if.htrans), 32'(IDLE));
    tick();
    #2;
    chk("ho_grant", 32'(core_grant), 32'd1);
    chk("ho_addr", bus_if.haddr, 32'h200);
    tick();
    drive(1, IDLE, 32'h200, 1'b0, 3'b000, 1'b0);
    bus_if.hrdata = 32'h12345678;
    #2;
    chk("ho_rdata", core_if.hrdata, 32'h12345678);
    tick();

    // INCR4 burst by the core; SPI requests mid-burst
    drive(1, NONSEQ, 32'h300, 1'b0, 3'b011, 1'b0);
    tick();
    for (int b = 1; b < 4; b++) begin
      drive(1, SEQ, 32'h300 + 32'(b * 4), 1'b0, 3'b011, 1'b0);
      drive(0, NONSEQ, 32'h800, 1'b1, 3'b000, 1'b0);
      #2;
      chk("burst_addr", bus_if.haddr, 32'h300 + 32'(b * 4));
      chk("burst_spi_stall", 32'(spi_if.hready), 32'd0);
      tick();
    end
    drive(1, IDLE, 32'h30C, 1'b0, 3'b000, 1'b0);
    #2;
    chk("burst_end_spi_stall", 32'(spi_if.hready), 32'd0);
    chk("burst_end_grant", 32'(core_grant), 32'd1);
    tick();
    #2;
    chk("burst_spi_grant", 32'(core_grant), 32'd0);
    chk("burst_spi_addr", bus_if.haddr, 32'h800);
    tick();
    drive(0, IDLE, 32'h800, 1'b0, 3'b000, 1'b0);

    // locked core sequence; SPI waits
    drive(1, NONSEQ, 32'h400, 1'b1, 3'b000, 1'b1);
    tick();
    drive(0, NONSEQ, 32'h500, 1'b1, 3'b000, 1'b0);
    tick();
    drive(1, IDLE, 32'h400, 1'b0, 3'b000, 1'b1);
    tick();
    #2;
    chk("lock_hold_grant", 32'(core_grant), 32'd1);
    drive(1, NONSEQ, 32'h404, 1'b1, 3'b000, 1'b1);
    tick();
    drive(1, IDLE, 32'h404, 1'b0, 3'b000, 1'b0);
    #2;
    chk("lock_release_stall", 32'(spi_if.hready), 32'd0);
    tick();
    #2;
    chk("lock_spi_grant", 32'(core_grant), 32'd0);
    chk("lock_spi_addr", bus_if.haddr, 32'h500);
    tick();

    // wait states then two-cycle ERROR on the SPI data phase
    drive(0, IDLE, 32'h500, 1'b0, 3'b000, 1'b0);
    drive(1, NONSEQ, 32'h700, 1'b0, 3'b000, 1'b0);
    bus_if.hready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #2;
      chk("wait_addr", bus_if.haddr, 32'h500);
      tick();
    end
    bus_if.hresp = 1'b1;
    #2;
    chk("err1_spi_hresp", 32'(spi_if.hresp), 32'd1);
    chk("err1_core_hresp", 32'(core_if.hresp), 32'd0);
    tick();
    bus_if.hready = 1'b1;
    #2;
    chk("err2_spi_hresp", 32'(spi_if.hresp), 32'd1);
    tick();
    bus_if.hresp = 1'b0;
    #2;
    chk("err_ho_grant", 32'(core_grant), 32'd1);
    chk("err_ho_addr", bus_if.haddr, 32'h700);
    tick();

    // asynchronous reset during the core data phase
    drive(1, NONSEQ, 32'h704, 1'b0, 3'b000, 1'b0);
    drive(0, IDLE, 32'h900, 1'b0, 3'b000, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_grant", 32'(core_grant), 32'd0);
    chk("arst_addr", bus_if.haddr, 32'h900);
    chk("arst_core_stall", 32'(core_if.hready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      core_rst = ($urandom_range(0, 9) == 0);
      bus_if.hready = ($urandom_range(0, 3) != 0);
      bus_if.hresp = ($urandom_range(0, 7) == 0);
      bus_if.hrdata = $urandom;
      rand_master(0);
      rand_master(1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-master AHB-Lite arbiter that shares the single system bus (router, RAM, registers) between the SPI loader and the RISC-V core. It multiplexes address/control and write data from the current owner onto the shared bus. It routes the slave's ready/response back to the correct master and stalls the non-owner. Ownership changes only at safe address-phase boundaries. The SPI loader has priority and holds the bus exclusively while the core is in reset.

## Interface
Parameters: none (AHB-Lite, 32-bit address/data fixed).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- core_rst  in  1  core reset from SPI loader; high forces SPI ownership
- spi_htrans / spi_haddr / spi_hwrite / spi_hsize / spi_hburst / spi_hprot / spi_hmastlock  in  2/32/1/3/3/4/1  SPI master address phase
- spi_hwdata  in  32  SPI master write data
- spi_hready  out  1  ready to SPI master
- spi_hresp  out  1  response to SPI master
- spi_hrdata  out  32  read data to SPI master
- core_htrans … core_hmastlock, core_hwdata  in  same widths  core master signals
- core_hready, core_hresp, core_hrdata  out  1/1/32  core master returns
- htrans, haddr, hwrite, hsize, hburst, hprot, hmastlock, hwdata  out  2/32/1/3/3/4/1/32  shared bus to router
- hready, hresp  in  1/1  shared bus slave ready/response
- hrdata  in  32  shared bus read data
- core_grant  out  1  registered; 1 = core owns address phase

## Operation
- State registers:
  - addr_owner (0 = SPI, 1 = core); equals core_grant.
  - dp_owner (owner of the in-flight data phase).
  - dp_valid (data phase is a real transfer, i.e. its address phase was NONSEQ/SEQ).
- Address mux: shared htrans..hmastlock = addr_owner's signals.
- Data mux: hwdata = dp_owner's hwdata.
- hrdata is broadcast unchanged to both masters.
- hresp goes to dp_owner when dp_valid; the other master sees 0.
- Owner ready: hready_owner = hready.
- Non-owner ready:
  - if dp_valid and dp_owner == non-owner: hready (completes its last transfer);
  - else 1 when its htrans = IDLE, 0 when NONSEQ/SEQ/BUSY (stalled, master holds its request).
- Handover boundary: a cycle with hready = 1, owner htrans = IDLE, owner hmastlock = 0.
- Handover decision at a boundary:
  - core_rst = 1: addr_owner <= SPI.
  - else if the non-owner presents NONSEQ: addr_owner <= non-owner.
  - else ownership parks on the current owner.
- No handover during bursts (SEQ/BUSY) or locked sequences, regardless of the other master.
- Fixed priority: core_rst overrides everything. Otherwise first-come at idle boundaries, because the owner is by definition idle there.
- Data-phase registers, updated when hready = 1:
  - dp_owner <= addr_owner;
  - dp_valid <= (htrans[1] == 1).
- Reset values: addr_owner = 0, dp_owner = 0, dp_valid = 0, core_grant = 0.
- Resulting outputs after reset:
  - shared bus mirrors SPI;
  - spi_hready = hready;
  - core_hready = 1 if core idle, else 0;
  - hresp outputs 0.

## Timing
- Same-owner transfers: zero added latency; the address path is combinational from the registered owner.
- Handover cost: non-owner NONSEQ at boundary cycle N → granted at N+1, its address appears on the bus at N+1.
  - The bus shows the previous owner's IDLE during N.
  - Non-owner hready = 0 during N, so its address is held.
- Wait states (hready = 0): all state registers hold; the non-owner stays stalled.
- Two-cycle ERROR: hresp routed to dp_owner in both cycles. A handover is permitted on the second cycle if the owner is IDLE there.
- core_rst rising while core owns the bus: ownership returns to SPI at the next boundary. The in-flight core data phase completes normally.
- Async reset mid-transfer: immediate return to reset values; the in-flight transfer is abandoned.

## Test plan
- SPI-only traffic: reset, core_rst = 1, SPI NONSEQ write haddr = 0x100, hwdata = 0xDEADBEEF.
  - Bus shows the write in the same cycle, hwdata on the next.
  - core_grant stays 0.
- Handover: core_rst = 0, SPI idle, core NONSEQ read 0x200.
  - core_hready = 0 for one cycle; bus shows the core read one cycle later.
  - core_grant = 1; core_hrdata = slave hrdata.
- Contention during burst: core owns an INCR4 at 0x300; SPI raises NONSEQ mid-burst.
  - All 4 beats complete on the bus; spi_hready = 0 throughout.
  - SPI is granted one cycle after the core goes IDLE.
- Locked sequence: core hmastlock = 1 across two transfers separated by IDLE while SPI requests.
  - No handover until hmastlock = 0 with IDLE.
- Wait states/error: slave holds hready = 0 for 3 cycles, then ERROR.
  - Only dp_owner sees hresp = 1 for both ERROR cycles.
  - Owner and address are stable throughout.
- Reset mid-operation: assert reset during a core data phase.
  - core_grant = 0, the bus mirrors SPI and the core master is stalled.
